// File: rtl/devbus_pkg.sv
// Shared types and constants for the device-bus hub.
package devbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Value returned on a read that times out; sliced down to the bus width (max 64 bits).
  localparam logic [63:0] RD_FAULT_VALUE = '1;

endpackage

// File: rtl/devbus_fifo.sv
// Synchronous FIFO with power-of-two depth; an extra wrap bit on each pointer separates full from empty.
module devbus_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/devbus_hub.sv
// Device-bus hub: N_DEV TX FIFOs and RX holding registers between the CPU main bus and devices.
// Optional stall timeout with sticky fault is enabled by defining DEVBUS_TIMEOUT_EN.
module devbus_hub
  import devbus_pkg::*;
#(
  parameter int WIDTH_MAIN = 8,
  parameter int N_DEV      = 6,
  parameter int TX_DEPTH   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH_MAIN-1:0]       main_in,
  input  logic [N_DEV-1:0]            dev_load_main,
  input  logic [N_DEV-1:0]            dev_assert_main,
  output logic [WIDTH_MAIN-1:0]       main_out,
  output logic                        main_oe,
  output logic                        stall,
  output logic                        bus_err,
  output logic                        fault,
  output logic [N_DEV*WIDTH_MAIN-1:0] tx_data,
  output logic [N_DEV-1:0]            tx_valid,
  input  logic [N_DEV-1:0]            tx_ready,
  input  logic [N_DEV*WIDTH_MAIN-1:0] rx_data,
  input  logic [N_DEV-1:0]            rx_valid,
  output logic [N_DEV-1:0]            rx_ready
);

  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
    $error("devbus_hub: TX_DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  // Device handshakes: a byte moves on any cycle where valid && ready are both high.
  state_t                state, state_n;
  logic [N_DEV-1:0]      fifo_full, fifo_empty, push, pop;
  logic [N_DEV-1:0]      wr_req, rd_req, serve, capture, rx_full;
  logic [WIDTH_MAIN-1:0] rx_reg [N_DEV];
  logic                  req_any, req_multi, req_ok, blocked, fault_cycle;

  assign req_any   = |{dev_load_main, dev_assert_main};
  assign req_multi = !$onehot0({dev_load_main, dev_assert_main});
  assign req_ok    = req_any && !req_multi;
  assign wr_req    = req_ok ? dev_load_main   : '0;
  assign rd_req    = req_ok ? dev_assert_main : '0;
  assign blocked   = |(wr_req & fifo_full) || |(rd_req & ~rx_full);

  assign fault_cycle = (state == ST_FAULT);
  assign stall       = blocked && !fault_cycle;
  assign bus_err     = req_multi;

  assign push     = wr_req & ~fifo_full & {N_DEV{!fault_cycle}};
  assign pop      = ~fifo_empty & tx_ready;
  assign tx_valid = ~fifo_empty;
  assign serve    = rd_req & rx_full & {N_DEV{!fault_cycle}};
  assign capture  = rx_valid & ~rx_full;
  assign rx_ready = ~rx_full;

  for (genvar i = 0; i < N_DEV; i++) begin : g_ch
    devbus_fifo #(
      .WIDTH(WIDTH_MAIN),
      .DEPTH(TX_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push[i]),
      .pop  (pop[i]),
      .wdata(main_in),
      .rdata(tx_data[i*WIDTH_MAIN +: WIDTH_MAIN]),
      .full (fifo_full[i]),
      .empty(fifo_empty[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) rx_full <= '0;
    else       rx_full <= (rx_full & ~serve) | capture;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_DEV; i++) begin
      if (capture[i]) rx_reg[i] <= rx_data[i*WIDTH_MAIN +: WIDTH_MAIN];
    end
  end

  always_comb begin
    main_out = '0;
    main_oe  = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      if (serve[i]) begin
        main_out = rx_reg[i];
        main_oe  = 1'b1;
      end
    end
    if (fault_cycle && |rd_req) begin
      main_out = RD_FAULT_VALUE[WIDTH_MAIN-1:0];
      main_oe  = 1'b1;
    end
  end

`ifdef DEVBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             fault_q;

  // IDLE contributes the first stall cycle, so WAIT gives up after TIMEOUT-1 more.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: if (blocked) begin
        state_n = ST_WAIT;
        cnt_n   = '0;
      end
      ST_WAIT: begin
        if (!blocked)                       state_n = ST_IDLE;
        else if (cnt == CNT_W'(TIMEOUT - 2)) state_n = ST_FAULT;
        else                                cnt_n   = cnt + CNT_W'(1);
      end
      ST_FAULT: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      fault_q <= fault_q || (state_n == ST_FAULT);
    end
  end

  assign fault = fault_q;
`else
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (blocked)  state_n = ST_WAIT;
      ST_WAIT: if (!blocked) state_n = ST_IDLE;
      default:               state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_devbus_hub.sv
// Directed and random bench for devbus_hub against a queue-based reference model.
// Timeout checks are included only when DEVBUS_TIMEOUT_EN is defined.
module tb_devbus_hub;

  localparam int W  = 8;
  localparam int N  = 6;
  localparam int D  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   main_in;
  logic [N-1:0]   dev_load_main, dev_assert_main;
  logic [W-1:0]   main_out;
  logic           main_oe, stall, bus_err, fault;
  logic [N*W-1:0] tx_data;
  logic [N-1:0]   tx_valid, tx_ready;
  logic [N*W-1:0] rx_data;
  logic [N-1:0]   rx_valid, rx_ready;

  devbus_hub #(
    .WIDTH_MAIN(W), .N_DEV(N), .TX_DEPTH(D), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .main_in(main_in),
    .dev_load_main(dev_load_main), .dev_assert_main(dev_assert_main),
    .main_out(main_out), .main_oe(main_oe), .stall(stall), .bus_err(bus_err),
    .fault(fault), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] exp_q [N][$];
  bit           rx_has [N];
  logic [W-1:0] rx_val [N];
  int           stall_run;
  bit           fault_m;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model, advance the model, then step one clock.
  task automatic run_cycle();
    int           ones, ch;
    bit           one, is_wr, is_rd, blocked, fault_now, served;
    bit           exp_oe;
    logic [W-1:0] exp_out;
    logic [N-1:0] exp_txv, exp_rdy;
    #1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        exp_q[i].delete();
        rx_has[i] = 1'b0;
      end
      stall_run = 0;
      fault_m   = 1'b0;
    end else begin
      ones  = $countones({dev_load_main, dev_assert_main});
      one   = (ones == 1);
      ch    = 0;
      is_wr = 1'b0;
      is_rd = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (dev_load_main[i])   begin ch = i; is_wr = one; end
        if (dev_assert_main[i]) begin ch = i; is_rd = one; end
      end
      blocked = is_wr ? (exp_q[ch].size() == D) : (is_rd ? !rx_has[ch] : 1'b0);
`ifdef DEVBUS_TIMEOUT_EN
      fault_now = (stall_run == TO);
`else
      fault_now = 1'b0;
`endif
      exp_oe  = is_rd && (fault_now || rx_has[ch]);
      exp_out = !exp_oe ? '0 : (fault_now ? '1 : rx_val[ch]);
      for (int i = 0; i < N; i++) begin
        exp_txv[i] = (exp_q[i].size() > 0);
        exp_rdy[i] = !rx_has[i];
      end
      check("stall",    32'(stall),    32'(blocked && !fault_now));
      check("main_oe",  32'(main_oe),  32'(exp_oe));
      check("main_out", 32'(main_out), 32'(exp_out));
      check("bus_err",  32'(bus_err),  32'(ones > 1));
      check("fault",    32'(fault),    32'(fault_m || fault_now));
      check("tx_valid", 32'(tx_valid), 32'(exp_txv));
      check("rx_ready", 32'(rx_ready), 32'(exp_rdy));
      for (int i = 0; i < N; i++) begin
        if (exp_q[i].size() > 0)
          check($sformatf("tx_data ch%0d", i), 32'(tx_data[i*W +: W]), 32'(exp_q[i][0]));
      end
      for (int i = 0; i < N; i++) begin
        if (exp_q[i].size() > 0 && tx_ready[i]) void'(exp_q[i].pop_front());
      end
      if (is_wr && !blocked && !fault_now) exp_q[ch].push_back(main_in);
      served = is_rd && rx_has[ch] && !fault_now;
      for (int i = 0; i < N; i++) begin
        if (rx_valid[i] && !rx_has[i]) begin
          rx_has[i] = 1'b1;
          rx_val[i] = rx_data[i*W +: W];
        end
      end
      if (served) rx_has[ch] = 1'b0;
      stall_run = (blocked && !fault_now) ? stall_run + 1 : 0;
      fault_m   = fault_m || fault_now;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dev_load_main   = '0;
    dev_assert_main = '0;
    tx_ready        = '0;
    rx_valid        = '0;
  endtask

  initial begin
    int r, a, b;
    logic [2*N-1:0] req;
    reset   = 1'b1;
    main_in = '0;
    rx_data = '0;
    idle_inputs();
    stall_run = 0;
    fault_m   = 1'b0;
    run_cycle();
    run_cycle();
    reset = 1'b0;

    // Reset state
    #1;
    check("rst stall",    32'(stall),    32'd0);
    check("rst main_oe",  32'(main_oe),  32'd0);
    check("rst main_out", 32'(main_out), 32'd0);
    check("rst bus_err",  32'(bus_err),  32'd0);
    check("rst fault",    32'(fault),    32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst rx_ready", 32'(rx_ready), 32'h3F);
    run_cycle();

    // Single write to ch2
    dev_load_main = 6'b000100;
    main_in       = 8'h5A;
    run_cycle();
    dev_load_main = '0;
    #1;
    check("wr ch2 tx_valid", 32'(tx_valid[2]), 32'd1);
    check("wr ch2 tx_data",  32'(tx_data[2*W +: W]), 32'h5A);
    check("wr ch2 stall",    32'(stall), 32'd0);
    run_cycle();
    tx_ready = 6'b000100;
    run_cycle();
    tx_ready = '0;

    // Overfill ch0: fifth write stalls until a pop frees a slot
    for (int k = 0; k < 5; k++) begin
      dev_load_main = 6'b000001;
      main_in       = 8'(8'h10 + k);
      #1;
      check("fill stall", 32'(stall), 32'(k == 4));
      run_cycle();
    end
    tx_ready = 6'b000001;
    #1;
    check("full pop stall", 32'(stall), 32'd1);
    run_cycle();
    tx_ready = '0;
    #1;
    check("post pop stall", 32'(stall), 32'd0);
    check("post pop head",  32'(tx_data[0 +: W]), 32'h11);
    run_cycle();
    dev_load_main = '0;
    tx_ready      = 6'b000001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain order", 32'(tx_data[0 +: W]), 32'(8'h11 + k));
      run_cycle();
    end
    tx_ready = '0;
    #1;
    check("drained", 32'(tx_valid[0]), 32'd0);

    // Read ch3 while empty, then device supplies 0xC3
    dev_assert_main = 6'b001000;
    #1;
    check("rd empty stall", 32'(stall),   32'd1);
    check("rd empty oe",    32'(main_oe), 32'd0);
    rx_valid           = 6'b001000;
    rx_data[3*W +: W]  = 8'hC3;
    #1;
    check("rd capture stall", 32'(stall),   32'd1);
    check("rd capture oe",    32'(main_oe), 32'd0);
    run_cycle();
    rx_valid = '0;
    #1;
    check("rd data",  32'(main_out),    32'hC3);
    check("rd oe",    32'(main_oe),     32'd1);
    check("rd stall", 32'(stall),       32'd0);
    check("rd full",  32'(rx_ready[3]), 32'd0);
    run_cycle();
    dev_assert_main = '0;
    #1;
    check("rd cleared", 32'(rx_ready[3]), 32'd1);
    run_cycle();

    // Illegal strobe combination
    dev_load_main   = 6'b000001;
    dev_assert_main = 6'b000010;
    #1;
    check("multi bus_err", 32'(bus_err), 32'd1);
    check("multi stall",   32'(stall),   32'd0);
    run_cycle();
    idle_inputs();
    #1;
    check("multi pulse", 32'(bus_err),     32'd0);
    check("multi nopush", 32'(tx_valid[0]), 32'd0);
    run_cycle();

`ifdef DEVBUS_TIMEOUT_EN
    // Read ch1 that never gets data
    dev_assert_main = 6'b000010;
    for (int k = 0; k < TO; k++) begin
      #1;
      check("to stall", 32'(stall), 32'd1);
      check("to fault", 32'(fault), 32'd0);
      run_cycle();
    end
    #1;
    check("to data",  32'(main_out), 32'hFF);
    check("to oe",    32'(main_oe),  32'd1);
    check("to stall", 32'(stall),    32'd0);
    check("to fault", 32'(fault),    32'd1);
    run_cycle();
    dev_assert_main = '0;
    #1;
    check("to sticky", 32'(fault), 32'd1);
    run_cycle();
`endif

    // Reset during WAIT with bytes queued on ch4
    for (int k = 0; k < 3; k++) begin
      dev_load_main = 6'b010000;
      main_in       = 8'($urandom);
      run_cycle();
    end
    dev_load_main   = '0;
    dev_assert_main = 6'b100000;
    run_cycle();
    run_cycle();
    #1;
    check("wait stall", 32'(stall), 32'd1);
    reset = 1'b1;
    run_cycle();
    reset           = 1'b0;
    dev_assert_main = '0;
    #1;
    check("rst wait stall", 32'(stall),    32'd0);
    check("rst wait txv",   32'(tx_valid), 32'd0);
    check("rst wait fault", 32'(fault),    32'd0);
    run_cycle();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 15);
      dev_load_main   = '0;
      dev_assert_main = '0;
      if (r < 8) begin
        dev_load_main[$urandom_range(0, N-1)] = 1'b1;
      end else if (r < 14) begin
        dev_assert_main[$urandom_range(0, N-1)] = 1'b1;
      end else if (r == 15) begin
        a   = $urandom_range(0, 2*N-1);
        b   = (a + 1 + $urandom_range(0, 2*N-2)) % (2*N);
        req = (12'b1 << a) | (12'b1 << b);
        {dev_load_main, dev_assert_main} = req;
      end
      main_in  = 8'($urandom);
      tx_ready = 6'($urandom);
      rx_valid = 6'($urandom) & 6'($urandom);
      for (int i = 0; i < N; i++) rx_data[i*W +: W] = 8'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    reset = 1'b0;
    idle_inputs();
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
